rtc_bus_arbiter: RTL and testbench

Arbitrated bus-cycle engine for the RTC's multiplexed address/data bus (A/D select, CS#, RD#, WR#). Two requesters share the bus: port 0 is the periodic register-read sequencer, and port 1 is the user configuration/write path. The block grants one transaction at a time using round-robin, then runs the full four-phase bus cycle: address, gap, data, gap. It returns read data and a one-cycle acknowledge to the granted port.

---
 rtl/rtc_bus_arbiter_if.sv | 33 +++
 rtl/rtc_bus_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_rtc_bus_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rtc_bus_arbiter_if.sv
// Requester, acknowledge and multiplexed A/D bus signals of the RTC bus arbiter.
// The master side holds the two requesters and the external bus; the slave side is the arbiter.
interface rtc_bus_arbiter_if;
    logic       req0;
    logic       req1;
    logic       rw0;
    logic       rw1;
    logic [7:0] addr0;
    logic [7:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata;
    logic       busy;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;
    logic       a_d;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;

    modport master (
        output req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, ad_in,
        input  ack0, ack1, rdata, busy, ad_out, ad_oe, a_d, cs_n, rd_n, wr_n
    );

    modport slave (
        input  req0, req1, rw0, rw1, addr0, addr1, wdata0, wdata1, ad_in,
        output ack0, ack1, rdata, busy, ad_out, ad_oe, a_d, cs_n, rd_n, wr_n
    );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Two-port round-robin arbiter driving the RTC's four-phase multiplexed A/D bus cycle
// (address, gap, data, gap) and returning read data with a one-cycle acknowledge.
module rtc_bus_arbiter #(
    parameter int unsigned PH_LEN = 7
) (
    input  logic               clk_i,
    input  logic               reset,
    rtc_bus_arbiter_if.slave   bus
);
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_GAP1 = 3'd2,
        ST_DATA = 3'd3,
        ST_GAP2 = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [4:0] CNT_LOAD = 5'(PH_LEN - 32'd1);

    state_t     state_r, state_s;
    logic [4:0] cnt_r, cnt_s;
    logic       gnt_r, last_r, rw_r;
    logic [7:0] addr_r, wdata_r;
    logic       any_req_s, win_s;
    logic       cur_port_s, cur_rw_s;
    logic [7:0] cur_addr_s, cur_wdata_s;

    logic       cs_n_r, rd_n_r, wr_n_r, a_d_r, ad_oe_r, ack0_r, ack1_r, busy_r;
    logic [7:0] ad_out_r, rdata_r;
    logic       cs_n_s, rd_n_s, wr_n_s, a_d_s, ad_oe_s, ack0_s, ack1_s, busy_s;
    logic [7:0] ad_out_s, rdata_s;

    assign any_req_s = bus.req0 | bus.req1;
    // On a tie the port not served last wins; otherwise whichever port is requesting.
    assign win_s     = (bus.req0 & bus.req1) ? ~last_r : bus.req1;

    // Outputs are registered from the next state, so in IDLE the winner's fields are used
    // directly because they are latched on the same edge.
    assign cur_port_s  = (state_r == ST_IDLE) ? win_s : gnt_r;
    assign cur_rw_s    = (state_r == ST_IDLE) ? (win_s ? bus.rw1 : bus.rw0) : rw_r;
    assign cur_addr_s  = (state_r == ST_IDLE) ? (win_s ? bus.addr1 : bus.addr0) : addr_r;
    assign cur_wdata_s = (state_r == ST_IDLE) ? (win_s ? bus.wdata1 : bus.wdata0) : wdata_r;

    // State and phase counter register.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 5'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Transaction latch and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            gnt_r   <= 1'b0;
            last_r  <= 1'b1;
            rw_r    <= 1'b0;
            addr_r  <= 8'd0;
            wdata_r <= 8'd0;
        end else if (state_r == ST_IDLE && any_req_s) begin
            gnt_r   <= win_s;
            rw_r    <= cur_rw_s;
            addr_r  <= cur_addr_s;
            wdata_r <= cur_wdata_s;
        end else if (state_r == ST_DONE) begin
            last_r  <= gnt_r;
        end else begin
            last_r  <= last_r;
        end
    end

    // Next-state and phase counter logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_s = ST_ADDR;
                    cnt_s   = CNT_LOAD;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = 5'd0;
                end
            end
            ST_ADDR, ST_GAP1, ST_DATA: begin
                if (cnt_r == 5'd0) begin
                    state_s = state_t'(state_r + 3'd1);
                    cnt_s   = CNT_LOAD;
                end else begin
                    cnt_s   = cnt_r - 5'd1;
                end
            end
            ST_GAP2: begin
                if (cnt_r == 5'd0) begin
                    state_s = ST_DONE;
                    cnt_s   = 5'd0;
                end else begin
                    cnt_s   = cnt_r - 5'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                cnt_s   = 5'd0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = 5'd0;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        cs_n_s   = 1'b1;
        rd_n_s   = 1'b1;
        wr_n_s   = 1'b1;
        a_d_s    = 1'b1;
        ad_oe_s  = 1'b0;
        ad_out_s = ad_out_r;
        ack0_s   = 1'b0;
        ack1_s   = 1'b0;
        busy_s   = 1'b1;
        case (state_s)
            ST_IDLE: busy_s = 1'b0;
            ST_ADDR: begin
                a_d_s    = 1'b0;
                cs_n_s   = 1'b0;
                wr_n_s   = 1'b0;
                ad_oe_s  = 1'b1;
                ad_out_s = cur_addr_s;
            end
            ST_GAP1, ST_GAP2: busy_s = 1'b1;
            ST_DATA: begin
                cs_n_s = 1'b0;
                if (cur_rw_s) begin
                    rd_n_s = 1'b0;
                end else begin
                    wr_n_s   = 1'b0;
                    ad_oe_s  = 1'b1;
                    ad_out_s = cur_wdata_s;
                end
            end
            ST_DONE: begin
                ack0_s = ~cur_port_s;
                ack1_s = cur_port_s;
            end
            default: busy_s = 1'b0;
        endcase
        // Capture on the edge that ends the last DATA cycle, while rd_n is still low.
        if (state_r == ST_DATA && cnt_r == 5'd0 && rw_r) begin
            rdata_s = bus.ad_in;
        end else begin
            rdata_s = rdata_r;
        end
    end

    // Output register.
    always_ff @(posedge clk_i) begin
        if (reset) begin
            cs_n_r   <= 1'b1;
            rd_n_r   <= 1'b1;
            wr_n_r   <= 1'b1;
            a_d_r    <= 1'b1;
            ad_oe_r  <= 1'b0;
            ad_out_r <= 8'd0;
            ack0_r   <= 1'b0;
            ack1_r   <= 1'b0;
            busy_r   <= 1'b0;
            rdata_r  <= 8'd0;
        end else begin
            cs_n_r   <= cs_n_s;
            rd_n_r   <= rd_n_s;
            wr_n_r   <= wr_n_s;
            a_d_r    <= a_d_s;
            ad_oe_r  <= ad_oe_s;
            ad_out_r <= ad_out_s;
            ack0_r   <= ack0_s;
            ack1_r   <= ack1_s;
            busy_r   <= busy_s;
            rdata_r  <= rdata_s;
        end
    end

    assign bus.cs_n   = cs_n_r;
    assign bus.rd_n   = rd_n_r;
    assign bus.wr_n   = wr_n_r;
    assign bus.a_d    = a_d_r;
    assign bus.ad_oe  = ad_oe_r;
    assign bus.ad_out = ad_out_r;
    assign bus.ack0   = ack0_r;
    assign bus.ack1   = ack1_r;
    assign bus.busy   = busy_r;
    assign bus.rdata  = rdata_r;
endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Directed bench for rtc_bus_arbiter: reads, writes, ties, late request, mid-cycle reset
// and the PH_LEN=2 corner, checked cycle by cycle with hand-derived expected strobes.
module tb_rtc_bus_arbiter;
    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    rtc_bus_arbiter_if bus7 ();
    rtc_bus_arbiter_if bus2 ();

    rtc_bus_arbiter #(.PH_LEN(7)) dut7 (.clk_i(clk), .reset(reset), .bus(bus7.slave));
    rtc_bus_arbiter #(.PH_LEN(2)) dut2 (.clk_i(clk), .reset(reset), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit order: a_d, cs_n, rd_n, wr_n, ad_oe, busy, ack0, ack1
    logic [7:0] v7, v2;
    assign v7 = {bus7.a_d, bus7.cs_n, bus7.rd_n, bus7.wr_n, bus7.ad_oe, bus7.busy, bus7.ack0, bus7.ack1};
    assign v2 = {bus2.a_d, bus2.cs_n, bus2.rd_n, bus2.wr_n, bus2.ad_oe, bus2.busy, bus2.ack0, bus2.ack1};

    function automatic logic [7:0] obs_vec(input int s);
        return (s == 0) ? v7 : v2;
    endfunction
    function automatic logic [7:0] obs_ad(input int s);
        return (s == 0) ? bus7.ad_out : bus2.ad_out;
    endfunction
    function automatic logic [7:0] obs_rd(input int s);
        return (s == 0) ? bus7.rdata : bus2.rdata;
    endfunction

    // Expected strobe vector in cycle k after the grant edge.
    function automatic logic [7:0] exp_vec(input int k, input int p, input int port, input logic rw);
        logic [7:0] r;
        int ph;
        ph = (k - 1) / p;
        if (k == 4 * p + 1) begin
            r    = 8'b1111_0100;
            r[1] = (port == 0);
            r[0] = (port == 1);
        end else if (ph == 0) begin
            r = 8'b0010_1100;
        end else if (ph == 2) begin
            r = rw ? 8'b1001_0100 : 8'b1010_1100;
        end else begin
            r = 8'b1111_0100;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic drive_req(input int s, input int port, input logic v);
        if (s == 0) begin
            if (port == 0) bus7.req0 = v; else bus7.req1 = v;
        end else begin
            if (port == 0) bus2.req0 = v; else bus2.req1 = v;
        end
    endtask

    task automatic set_fields(input int s, input int port, input logic rw, input logic [7:0] a, input logic [7:0] w);
        if (s == 0) begin
            if (port == 0) begin bus7.rw0 = rw; bus7.addr0 = a; bus7.wdata0 = w; end
            else begin bus7.rw1 = rw; bus7.addr1 = a; bus7.wdata1 = w; end
        end else begin
            if (port == 0) begin bus2.rw0 = rw; bus2.addr0 = a; bus2.wdata0 = w; end
            else begin bus2.rw1 = rw; bus2.addr1 = a; bus2.wdata1 = w; end
        end
    endtask

    task automatic set_adin(input int s, input logic [7:0] d);
        if (s == 0) bus7.ad_in = d; else bus2.ad_in = d;
    endtask

    // One full transaction from an IDLE negedge to the IDLE negedge after DONE.
    // ad_in carries the real value only in the last DATA cycle to pin the capture edge.
    task automatic run_txn(input int s, input int p, input int port, input logic rw,
                           input logic [7:0] a, input logic [7:0] w, input logic [7:0] adin,
                           input logic [7:0] exp_rd, input int late_k, input string tag);
        logic [7:0] e;
        set_fields(s, port, rw, a, w);
        set_adin(s, ~adin);
        drive_req(s, port, 1'b1);
        for (int k = 1; k <= 4 * p + 1; k++) begin
            @(negedge clk);
            e = exp_vec(k, p, port, rw);
            chk(tag, k, obs_vec(s), e);
            if (e[3]) chk({tag, "_ad"}, k, obs_ad(s), (k <= p) ? a : w);
            if (k == 3 * p) set_adin(s, adin); else set_adin(s, ~adin);
            if (k == late_k) drive_req(s, 1, 1'b1);
            if (k == 4 * p + 1) begin
                chk({tag, "_rdata"}, k, obs_rd(s), exp_rd);
                drive_req(s, port, 1'b0);
            end
        end
        @(negedge clk);
        chk({tag, "_idle"}, 0, obs_vec(s), 8'b1111_0000);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus7.req0 = 1'b0; bus7.req1 = 1'b0; bus7.ad_in = 8'h00;
        bus2.req0 = 1'b0; bus2.req1 = 1'b0; bus2.ad_in = 8'h00;
        set_fields(0, 0, 1'b0, 8'h00, 8'h00);
        set_fields(0, 1, 1'b0, 8'h00, 8'h00);
        set_fields(1, 0, 1'b0, 8'h00, 8'h00);
        set_fields(1, 1, 1'b0, 8'h00, 8'h00);

        @(negedge clk);
        chk("rst_vec7", 0, v7, 8'b1111_0000);
        chk("rst_rd7", 0, bus7.rdata, 8'h00);
        chk("rst_ad7", 0, bus7.ad_out, 8'h00);
        chk("rst_vec2", 0, v2, 8'b1111_0000);
        chk("rst_rd2", 0, bus2.rdata, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_vec7", 0, v7, 8'b1111_0000);

        run_txn(0, 7, 0, 1'b1, 8'h21, 8'h00, 8'h59, 8'h59, 0, "rd_p0");
        run_txn(0, 7, 1, 1'b0, 8'hF0, 8'h00, 8'h33, 8'h59, 0, "wr_p1");

        // Tie, then a repeated tie: expected order 0, 1, 0, 1.
        set_fields(0, 1, 1'b0, 8'h45, 8'h5A);
        drive_req(0, 1, 1'b1);
        run_txn(0, 7, 0, 1'b1, 8'h44, 8'h00, 8'hA5, 8'hA5, 0, "tie1_p0");
        run_txn(0, 7, 1, 1'b0, 8'h45, 8'h5A, 8'h00, 8'hA5, 0, "tie1_p1");
        set_fields(0, 1, 1'b1, 8'h47, 8'h00);
        drive_req(0, 1, 1'b1);
        run_txn(0, 7, 0, 1'b0, 8'h46, 8'h3C, 8'h00, 8'hA5, 0, "tie2_p0");
        run_txn(0, 7, 1, 1'b1, 8'h47, 8'h00, 8'hC3, 8'hC3, 0, "tie2_p1");

        // req1 raised in the middle of port 0's DATA phase.
        set_fields(0, 1, 1'b0, 8'h55, 8'hAA);
        run_txn(0, 7, 0, 1'b1, 8'h50, 8'h00, 8'h6B, 8'h6B, 17, "late_p0");
        run_txn(0, 7, 1, 1'b0, 8'h55, 8'hAA, 8'h00, 8'h6B, 0, "late_p1");

        // One-cycle reset during the DATA phase of a read.
        set_fields(0, 0, 1'b1, 8'h30, 8'h00);
        set_adin(0, 8'h11);
        drive_req(0, 0, 1'b1);
        repeat (16) @(negedge clk);
        chk("rstdata_pre", 16, v7, 8'b1001_0100);
        reset = 1'b1;
        drive_req(0, 0, 1'b0);
        @(negedge clk);
        chk("rstdata_vec", 0, v7, 8'b1111_0000);
        chk("rstdata_rd", 0, bus7.rdata, 8'h00);
        chk("rstdata_ad", 0, bus7.ad_out, 8'h00);
        reset = 1'b0;
        @(negedge clk);
        chk("rstdata_noack", 0, v7, 8'b1111_0000);
        run_txn(0, 7, 0, 1'b1, 8'h22, 8'h00, 8'h7E, 8'h7E, 0, "post_rst_p0");

        // PH_LEN=2 corner: ack at grant+9, strobes low for two cycles each.
        run_txn(1, 2, 0, 1'b1, 8'h0F, 8'h00, 8'h96, 8'h96, 0, "ph2_rd");
        run_txn(1, 2, 1, 1'b0, 8'h0E, 8'h81, 8'h00, 8'h96, 0, "ph2_wr");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
